// File: rtl/spiker_frame_ctrl.sv
// ============================================================================
// spiker_frame_ctrl
// ----------------------------------------------------------------------------
// Sequences one spike frame through the spiker core. The controller does four
// things:
//   - It reads the N_WORDS spike words from the adapter register file, one
//     word at a time.
//   - It streams those words to the core over a valid/ready input channel.
//   - It collects the core's N_WORDS result words and writes each one back
//     into the result register file with a one-cycle write strobe.
//   - It reports busy, done and timeout status, and raises an irq pulse when
//     a frame completes or times out.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   start_i          one-cycle start pulse; ignored while a frame is running
//   abort_i          one-cycle abort pulse; returns to idle without done/irq
//   rd_idx_o         index of the spike register being read
//   rd_data_i        combinational read data for rd_idx_o
//   core_in_valid_o  input beat valid
//   core_in_ready_i  core accepts the input beat
//   core_in_data_o   input beat data; the tail bits of the last word are zeroed
//   core_in_last_o   marks the final input beat
//   core_out_valid_i result beat valid
//   core_out_ready_o controller accepts the result beat
//   core_out_data_i  result beat data
//   res_we_o         result register write strobe (registered)
//   res_idx_o        result register index
//   res_data_o       result register data
//   busy_o           a frame is in progress
//   done_o           sticky frame-complete flag, cleared by the next start
//   err_timeout_o    sticky result-timeout flag, cleared by the next start
//   irq_o            one-cycle pulse on completion or timeout
// ============================================================================
module spiker_frame_ctrl #(
   parameter  int WIDTH          = 32,
   parameter  int N_SPIKES       = 784,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int N_WORDS        = (N_SPIKES + WIDTH - 1) / WIDTH,
   localparam int IW             = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   output logic [IW-1:0]    rd_idx_o,
   input  logic [WIDTH-1:0] rd_data_i,
   output logic             core_in_valid_o,
   input  logic             core_in_ready_i,
   output logic [WIDTH-1:0] core_in_data_o,
   output logic             core_in_last_o,
   input  logic             core_out_valid_i,
   output logic             core_out_ready_o,
   input  logic [WIDTH-1:0] core_out_data_i,
   output logic             res_we_o,
   output logic [IW-1:0]    res_idx_o,
   output logic [WIDTH-1:0] res_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_timeout_o,
   output logic             irq_o
);

   // Number of valid spike bits in the last word. Zero means the word is full.
   localparam int TAIL = N_SPIKES % WIDTH;

   // res_cnt must be able to hold N_WORDS itself, so it can be one bit wider than IW.
   localparam int CW = $clog2(N_WORDS + 1);

   // The timer only ever holds 0 .. TIMEOUT_CYCLES-1.
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [IW-1:0]    LAST_IDX  = IW'(N_WORDS - 1);
   localparam logic [CW-1:0]    FULL_CNT  = CW'(N_WORDS);
   localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [WIDTH-1:0] TAIL_MASK = (TAIL == 0) ? {WIDTH{1'b1}}
                                                         : ({WIDTH{1'b1}} >> (WIDTH - TAIL));

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      FINISH
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [IW-1:0]    feed_cnt;
   logic [CW-1:0]    res_cnt;
   logic [TW-1:0]    timer;

   logic             in_valid;
   logic             in_last;
   logic             in_fire;
   logic             out_ready;
   logic             out_fire;
   logic             res_full;
   logic             tmo_hit;
   logic             start_ok;

   logic             done_q;
   logic             err_q;
   logic             irq_q;

   logic             res_we_p1;
   logic [IW-1:0]    res_idx_p1;
   logic [WIDTH-1:0] res_data_p1;

   // Zero the spike bits beyond N_SPIKES on the final word of the frame.
   function automatic logic [WIDTH-1:0] tail_mask(input logic [WIDTH-1:0] data,
                                                  input logic             last);
      return last ? (data & TAIL_MASK) : data;
   endfunction

   assign res_full = (res_cnt == FULL_CNT);
   assign start_ok = (state == IDLE) && start_i && !abort_i;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_next = FEED;
            end
         end
         FEED: begin
            // Abort removes valid/ready in the same cycle, so no beat can fire.
            in_valid  = !abort_i;
            out_ready = !abort_i && !res_full;
            if (abort_i) begin
               state_next = IDLE;
            end else if (core_in_ready_i && (feed_cnt == LAST_IDX)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            out_ready = !abort_i && !res_full;
            if (abort_i) begin
               state_next = IDLE;
            end else if (res_full) begin
               state_next = FINISH;
            end else if (!core_out_valid_i && (timer == TMO_LAST)) begin
               tmo_hit    = 1'b1;
               state_next = IDLE;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_fire  = in_valid && core_in_ready_i;
   assign out_fire = out_ready && core_out_valid_i;
   assign in_last  = in_valid && (feed_cnt == LAST_IDX);

   // ------------------------------------------------------------------------
   // Frame counters, timeout timer and sticky status
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         feed_cnt <= '0;
         res_cnt  <= '0;
         timer    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_q <= 1'b0;

         if (start_ok) begin
            feed_cnt <= '0;
            res_cnt  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
         end

         if (in_fire) begin
            feed_cnt <= feed_cnt + 1'b1;
         end

         if (out_fire) begin
            res_cnt <= res_cnt + 1'b1;
         end

         // The timer measures DRAIN cycles since the most recent result beat.
         // Quiet cycles spent in FEED do not count towards the timeout.
         if (state == DRAIN) begin
            if (out_fire) begin
               timer <= '0;
            end else if (!tmo_hit) begin
               timer <= timer + 1'b1;
            end
         end else begin
            timer <= '0;
         end

         if (tmo_hit) begin
            err_q <= 1'b1;
            irq_q <= 1'b1;
         end

         if ((state == FINISH) && !abort_i) begin
            done_q <= 1'b1;
            irq_q  <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage p1: registered result write-back
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_we_p1   <= 1'b0;
         res_idx_p1  <= '0;
         res_data_p1 <= '0;
      end else begin
         res_we_p1 <= out_fire;
         if (out_fire) begin
            res_idx_p1  <= res_cnt[IW-1:0];
            res_data_p1 <= core_out_data_i;
         end
      end
   end

   assign rd_idx_o         = feed_cnt;
   assign core_in_valid_o  = in_valid;
   assign core_in_last_o   = in_last;
   assign core_in_data_o   = in_valid ? tail_mask(rd_data_i, in_last) : '0;
   assign core_out_ready_o = out_ready;
   assign res_we_o         = res_we_p1;
   assign res_idx_o        = res_idx_p1;
   assign res_data_o       = res_data_p1;
   assign busy_o           = (state != IDLE);
   assign done_o           = done_q;
   assign err_timeout_o    = err_q;
   assign irq_o            = irq_q;

endmodule

// File: tb/tb_spiker_frame_ctrl.sv
// ============================================================================
// tb_spiker_frame_ctrl
// ----------------------------------------------------------------------------
// Bench for spiker_frame_ctrl. It provides:
//   - A spike register-file model.
//   - An echo core model, which returns the bitwise inverse of every word it
//     receives.
//   - A scoreboard. Expected input beats and expected result writes are
//     queued when a frame is issued, and a monitor pops and compares them
//     whenever the DUT presents a beat or a write.
// ============================================================================
module tb_spiker_frame_ctrl;

   localparam int WIDTH    = 32;
   localparam int N_SPIKES = 784;
   localparam int TMO      = 16;
   localparam int NW       = (N_SPIKES + WIDTH - 1) / WIDTH;
   localparam int IW       = $clog2(NW);

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             start_i;
   logic             abort_i;
   logic [IW-1:0]    rd_idx_o;
   logic [WIDTH-1:0] rd_data_i;
   logic             core_in_valid_o;
   logic             core_in_ready_i;
   logic [WIDTH-1:0] core_in_data_o;
   logic             core_in_last_o;
   logic             core_out_valid_i;
   logic             core_out_ready_o;
   logic [WIDTH-1:0] core_out_data_i;
   logic             res_we_o;
   logic [IW-1:0]    res_idx_o;
   logic [WIDTH-1:0] res_data_o;
   logic             busy_o;
   logic             done_o;
   logic             err_timeout_o;
   logic             irq_o;

   always #5 clk = ~clk;

   spiker_frame_ctrl #(
      .WIDTH          (WIDTH),
      .N_SPIKES       (N_SPIKES),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .rd_idx_o         (rd_idx_o),
      .rd_data_i        (rd_data_i),
      .core_in_valid_o  (core_in_valid_o),
      .core_in_ready_i  (core_in_ready_i),
      .core_in_data_o   (core_in_data_o),
      .core_in_last_o   (core_in_last_o),
      .core_out_valid_i (core_out_valid_i),
      .core_out_ready_o (core_out_ready_o),
      .core_out_data_i  (core_out_data_i),
      .res_we_o         (res_we_o),
      .res_idx_o        (res_idx_o),
      .res_data_o       (res_data_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .err_timeout_o    (err_timeout_o),
      .irq_o            (irq_o)
   );

   // Spike register file. It covers the whole index range; unused words are zero.
   logic [WIDTH-1:0] spikes [2**IW];
   assign rd_data_i = spikes[rd_idx_o];

   logic [81:0] all_outs;
   assign all_outs = {rd_idx_o, core_in_valid_o, core_in_data_o, core_in_last_o,
                      core_out_ready_o, res_we_o, res_idx_o, res_data_o,
                      busy_o, done_o, err_timeout_o, irq_o};

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } in_t;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] data;
   } res_t;

   in_t              exp_in  [$];
   res_t             exp_res [$];
   logic [WIDTH-1:0] core_q  [$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int in_cnt = 0;
   int res_wr_cnt = 0;
   int returned = 0;
   int irq_cnt = 0;
   int limit = NW;
   int last_in_edge = 0;
   int b3_edge = 0;
   int err_edge = 0;
   bit in_rand = 1'b0;
   bit out_rand = 1'b0;
   bit extra_word = 1'b0;
   bit core_en = 1'b0;
   bit out_fire = 1'b0;
   bit prev_stall = 1'b0;
   bit prev_err = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // The last word carries only the spikes left over after the full words;
   // every bit above those spikes is sent as zero.
   function automatic logic [WIDTH-1:0] model_word(input int i);
      logic [WIDTH-1:0] w;
      int               used;
      w    = spikes[i];
      used = N_SPIKES - (NW - 1) * WIDTH;
      if (i == NW - 1) begin
         for (int b = used; b < WIDTH; b++) begin
            w[b] = 1'b0;
         end
      end
      return w;
   endfunction

   // Core model drive side: input ready, and the echo result stream.
   initial begin
      core_in_ready_i  = 1'b0;
      core_out_valid_i = 1'b0;
      core_out_data_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         core_in_ready_i = in_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (!core_en) begin
            core_out_valid_i = 1'b0;
         end else if (core_out_valid_i && !out_fire) begin
            core_out_valid_i = 1'b1;
         end else if (core_q.size() > 0 && returned < limit &&
                      (!out_rand || $urandom_range(0, 1) == 1)) begin
            core_out_valid_i = 1'b1;
            core_out_data_i  = core_q[0];
         end else begin
            core_out_valid_i = 1'b0;
         end
      end
   end

   // Monitor: scoreboard checks and core model receive side.
   initial begin
      in_t  ei;
      res_t er;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_stall = 1'b0;
            out_fire   = 1'b0;
            prev_err   = 1'b0;
         end else begin
            if (core_in_valid_o && prev_stall) begin
               check("in_hold", 96'(core_in_data_o), 96'(prev_data));
            end
            if (core_in_valid_o && core_in_ready_i) begin
               if (exp_in.size() == 0) begin
                  check("in_unexpected_beat", 96'(exp_in.size()), 96'(1));
               end else begin
                  ei = exp_in.pop_front();
                  check("in_data", 96'(core_in_data_o), 96'(ei.data));
                  check("in_last", 96'(core_in_last_o), 96'(ei.last));
               end
               core_q.push_back(~core_in_data_o);
               if (core_in_last_o && extra_word) begin
                  core_q.push_back(32'hDEAD_BEEF);
               end
               in_cnt++;
               last_in_edge = cyc + 1;
            end
            prev_stall = core_in_valid_o && !core_in_ready_i;
            prev_data  = core_in_data_o;
            out_fire   = core_out_valid_i && core_out_ready_o;
            if (out_fire) begin
               void'(core_q.pop_front());
               returned++;
               if (returned == 3) begin
                  b3_edge = cyc + 1;
               end
            end
            if (res_we_o) begin
               if (exp_res.size() == 0) begin
                  check("res_unexpected_write", 96'(exp_res.size()), 96'(1));
               end else begin
                  er = exp_res.pop_front();
                  check("res_idx", 96'(res_idx_o), 96'(er.idx));
                  check("res_data", 96'(res_data_o), 96'(er.data));
               end
               res_wr_cnt++;
            end
            if (irq_o) begin
               irq_cnt++;
            end
            if (err_timeout_o && !prev_err) begin
               err_edge = cyc;
            end
            prev_err = err_timeout_o;
         end
      end
   end

   task automatic new_frame();
      in_t  ei;
      res_t er;
      core_en = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      core_q.delete();
      exp_in.delete();
      exp_res.delete();
      in_cnt       = 0;
      res_wr_cnt   = 0;
      returned     = 0;
      irq_cnt      = 0;
      last_in_edge = 0;
      b3_edge      = 0;
      err_edge     = 0;
      for (int i = 0; i < NW; i++) begin
         ei.data = model_word(i);
         ei.last = (i == NW - 1);
         exp_in.push_back(ei);
         er.idx  = i;
         er.data = ~model_word(i);
         exp_res.push_back(er);
      end
      core_en = 1'b1;
   endtask

   task automatic pulse_start(input logic with_abort);
      @(posedge clk);
      #2;
      start_i = 1'b1;
      abort_i = with_abort;
      @(posedge clk);
      #2;
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy_o && k < max);
      check(name, 96'(busy_o), 96'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_in_cnt(input string name, input int n, input int max);
      int k;
      k = 0;
      while (in_cnt < n && k < max) begin
         @(posedge clk);
         #2;
         k++;
      end
      check(name, 96'(in_cnt), 96'(n));
   endtask

   task automatic random_spikes();
      for (int i = 0; i < 2**IW; i++) begin
         spikes[i] = (i < NW) ? WIDTH'($urandom) : '0;
      end
   endtask

   initial begin
      int exp_err_edge;
      rst_ni  = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      for (int i = 0; i < 2**IW; i++) begin
         spikes[i] = (i < NW) ? WIDTH'(i + 1) : '0;
      end
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_outputs", 96'(all_outs), 96'(0));
      rst_ni = 1'b1;
      @(negedge clk);
      check("reset_busy", 96'(busy_o), 96'(0));

      // Nominal frame: spikes[i] = i+1, core always ready, echo results.
      in_rand = 1'b0; out_rand = 1'b0; extra_word = 1'b0; limit = NW;
      new_frame();
      pulse_start(1'b0);
      wait_idle("nominal_end", 400);
      check("nominal_in_left", 96'(exp_in.size()), 96'(0));
      check("nominal_res_left", 96'(exp_res.size()), 96'(0));
      check("nominal_done", 96'(done_o), 96'(1));
      check("nominal_err", 96'(err_timeout_o), 96'(0));
      check("nominal_irq", 96'(irq_cnt), 96'(1));

      // Backpressure frame, with an extra offered result that must never be taken.
      random_spikes();
      spikes[NW-1] = 32'hFFFF_FFFF;
      in_rand = 1'b1; out_rand = 1'b1; extra_word = 1'b1; limit = NW + 1;
      new_frame();
      pulse_start(1'b0);
      wait_idle("bp_end", 1500);
      check("bp_in_left", 96'(exp_in.size()), 96'(0));
      check("bp_res_left", 96'(exp_res.size()), 96'(0));
      check("bp_results_taken", 96'(returned), 96'(NW));
      check("bp_done", 96'(done_o), 96'(1));
      check("bp_irq", 96'(irq_cnt), 96'(1));
      extra_word = 1'b0;

      // Timeout frame: three results only, plus a start pulse while draining.
      random_spikes();
      in_rand = 1'b0; out_rand = 1'b0; limit = 3;
      new_frame();
      pulse_start(1'b0);
      wait_in_cnt("tmo_fed", NW, 300);
      repeat (3) @(posedge clk);
      pulse_start(1'b0);
      wait_idle("tmo_end", 300);
      exp_err_edge = ((last_in_edge > b3_edge) ? last_in_edge : b3_edge) + TMO;
      check("tmo_err", 96'(err_timeout_o), 96'(1));
      check("tmo_done", 96'(done_o), 96'(0));
      check("tmo_irq", 96'(irq_cnt), 96'(1));
      check("tmo_edge", 96'(err_edge), 96'(exp_err_edge));
      check("tmo_writes", 96'(res_wr_cnt), 96'(3));
      check("tmo_no_restart", 96'(in_cnt), 96'(NW));

      // Abort once ten words have been fed.
      random_spikes();
      in_rand = 1'b0; out_rand = 1'b1; limit = NW;
      new_frame();
      pulse_start(1'b0);
      wait_in_cnt("abort_fed", 10, 100);
      abort_i = 1'b1;
      @(posedge clk);
      #2;
      abort_i = 1'b0;
      check("abort_busy", 96'(busy_o), 96'(0));
      repeat (6) @(negedge clk);
      check("abort_in_cnt", 96'(in_cnt), 96'(10));
      check("abort_irq", 96'(irq_cnt), 96'(0));
      check("abort_done", 96'(done_o), 96'(0));
      check("abort_err", 96'(err_timeout_o), 96'(0));
      check("abort_writes", 96'(res_wr_cnt), 96'(returned));

      // start_i together with abort_i in IDLE: nothing happens.
      new_frame();
      pulse_start(1'b1);
      repeat (4) @(negedge clk);
      check("startabort_busy", 96'(busy_o), 96'(0));
      check("startabort_in_cnt", 96'(in_cnt), 96'(0));

      // Asynchronous reset in the middle of FEED.
      in_rand = 1'b1; limit = NW;
      new_frame();
      pulse_start(1'b0);
      wait_in_cnt("rst_fed", 5, 100);
      rst_ni = 1'b0;
      #1;
      check("reset_mid_outputs", 96'(all_outs), 96'(0));
      repeat (2) @(posedge clk);
      #2;
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_mid_busy", 96'(busy_o), 96'(0));
      check("reset_mid_valid", 96'(core_in_valid_o), 96'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
